outer_prod_seq: RTL and testbench
=================================

# outer_prod_seq

Single-clock sequencer for the 16×16 outer-product datapath. It buffers one vector pair of sixteen 4-bit A values and sixteen 4-bit B values, arriving as a serial stream. It then drives one shared 4×4 multiplier through all 256 index pairs and emits C[i*16+j] = A[i]*B[j] in row-major order, one product per cycle. It sits on the fast-clock side, after the input synchroniser and before the output CDC FIFO.

## Interface
- N, 16: vector length; power of two, ≥2.
- DW, 4: element width; product width is 2*DW.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat qualifier.
- in_matrix_A  in  DW  A element for the current beat.
- in_matrix_B  in  DW  B element for the current beat.
- out_ready  in  1  downstream accept; present only with OUTER_BACKPRESSURE_EN.
- busy  out  1  high from the first accepted beat until the final product is accepted.
- out_valid  out  1  product qualifier.
- out_matrix  out  2*DW  product A[i]*B[j].
- out_last  out  1  high together with out_valid on product index N*N-1.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - in_valid=1 stores beat 0 into A[0] and B[0], sets ld_cnt=1 and moves to LOAD.
- LOAD:
  - Each in_valid=1 beat stores A[ld_cnt] and B[ld_cnt], then increments ld_cnt.
  - in_valid=0 cycles are gaps; contents and ld_cnt hold.
  - The beat with ld_cnt=N-1 moves to RUN, with ld_cnt wrapping to 0.
- RUN:
  - Issue counter idx runs 0..N*N-1; i=idx[high half], j=idx[low half].
  - The product is registered into out_matrix, and out_valid is set for the next cycle.
  - idx advances when the output register is empty or being accepted (!out_valid || out_ready).
  - After issuing idx=N*N-1 the block moves to DONE.
- DONE:
  - Waits for the last product to be accepted, then returns to IDLE and deasserts busy.
- in_valid in RUN or DONE is ignored; the buffer is not overwritten. Upstream must not overlap in_valid with out_valid.
- out_matrix=0 whenever out_valid=0.
- Arithmetic is unsigned DW×DW→2*DW and cannot overflow; 15*15=225.
- Reset mid-operation: every register returns to its reset value immediately. The buffer contents are don't-care, and the next frame starts fresh from IDLE.

## Timing
- Reset values: busy=0, out_valid=0, out_matrix=0, out_last=0, state=IDLE, counters=0.
- Latency without stalls:
  - Last input beat sampled at edge E.
  - First out_valid is visible after edge E+2.
  - All 256 products appear on 256 consecutive cycles.
  - busy falls after edge E+2+256.
- busy rises the cycle after the first accepted beat.
- Back-to-back frames: a new in_valid is accepted from the IDLE cycle that follows DONE, which is one cycle after the last product.
- With stalls: out_valid, out_matrix and out_last hold stable while out_ready=0, and idx does not advance.

## Configuration
- OUTER_BACKPRESSURE_EN defined:
  - The out_ready port exists and controls acceptance.
  - Each product holds until out_ready=1.
- Undefined:
  - The out_ready port is absent and acceptance is internally tied to 1.
  - Products stream every cycle, and latency is fixed at 2+256 cycles after the last beat.

## Structure
- Package outer_prod_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - localparams IDXW=$clog2(N*N) and LDW=$clog2(N);
  - the defaults for N and DW.
- One sub-module, vec_buf: an N-entry DW-bit register file with one write port and one asynchronous read port, instantiated twice (A and B).

## Test plan
- Reset held during random stimulus -> busy=0, out_valid=0, out_matrix=0; no output until a fresh load.
- A[k]=k, B[k]=15-k, contiguous beats -> first product 0, C[17]=1*14=14, C[255]=15*0=0; out_last only on index 255; exactly 256 outputs.
- All A=B=15 with a 3-cycle in_valid gap after beat 7 -> load completes on beat 15; all 256 outputs equal 225.
- in_valid pulsed during RUN with A=B=0 -> outputs unaffected; the buffer keeps the original frame.
- OUTER_BACKPRESSURE_EN, out_ready low for 5 cycles at index 100 -> out_matrix holds C[100] stable; no product is lost or duplicated.
- rst_n asserted at output index 50, then a new frame loaded -> outputs restart at index 0 with the new data.

Source files
------------

// File: rtl/outer_prod_pkg.sv
// Shared types and sizing for the outer-product sequencer.
// Optional feature macro: OUTER_BACKPRESSURE_EN (see outer_prod_seq).
package outer_prod_pkg;

    localparam int N_DEF  = 16;
    localparam int DW_DEF = 4;
    localparam int IDXW   = $clog2(N_DEF * N_DEF);
    localparam int LDW    = $clog2(N_DEF);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/outer_prod_seq_vec_buf.sv
// N-entry element buffer: one synchronous write port, one async read port.
// Used once for the A vector and once for the B vector.
module vec_buf
    import outer_prod_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                mem_q[k] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/outer_prod_seq.sv
// Outer-product sequencer: buffers N A/B beats, streams all N*N products.
// Define OUTER_BACKPRESSURE_EN to add the out_ready acceptance input.
module outer_prod_seq
    import outer_prod_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_matrix_A,
    input  logic [DW-1:0] in_matrix_B,
`ifdef OUTER_BACKPRESSURE_EN
    input  logic          out_ready,
`endif
    output logic            busy,
    output logic            out_valid,
    output logic [2*DW-1:0] out_matrix,
    output logic            out_last
);

    localparam int LW = $clog2(N);
    localparam int IW = $clog2(N * N);
    localparam int PW = 2 * DW;

    state_e          state_q;
    logic [LW-1:0]   ld_cnt_q;
    logic [IW-1:0]   idx_q;
    logic            rd_v_q;
    logic            rd_last_q;
    logic [DW-1:0]   op_a_q;
    logic [DW-1:0]   op_b_q;
    logic            busy_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic [PW-1:0]   out_matrix_q;

    logic            accept;
    logic            adv;
    logic            wr_en;
    logic            in_run;
    logic [LW-1:0]   ri;
    logic [LW-1:0]   rj;
    logic [DW-1:0]   a_rd;
    logic [DW-1:0]   b_rd;
    logic [PW-1:0]   prod;

`ifdef OUTER_BACKPRESSURE_EN
    assign accept = out_ready;
`else
    assign accept = 1'b1;
`endif

    // Both pipeline stages move together whenever the output slot frees up.
    assign adv    = !out_valid_q || accept;
    assign in_run = (state_q == RUN);
    assign wr_en  = in_valid && (state_q == IDLE || state_q == LOAD);
    assign ri     = idx_q[IW-1:LW];
    assign rj     = idx_q[LW-1:0];
    assign prod   = {{DW{1'b0}}, op_a_q} * {{DW{1'b0}}, op_b_q};

    vec_buf #(.N(N), .DW(DW), .AW(LW)) u_buf_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_en),
        .waddr_i (ld_cnt_q),
        .wdata_i (in_matrix_A),
        .raddr_i (ri),
        .rdata_o (a_rd)
    );

    vec_buf #(.N(N), .DW(DW), .AW(LW)) u_buf_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_en),
        .waddr_i (ld_cnt_q),
        .wdata_i (in_matrix_B),
        .raddr_i (rj),
        .rdata_o (b_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ld_cnt_q     <= '0;
            idx_q        <= '0;
            rd_v_q       <= 1'b0;
            rd_last_q    <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_matrix_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        ld_cnt_q <= LW'(1);
                        busy_q   <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (ld_cnt_q == LW'(N - 1)) begin
                            ld_cnt_q <= '0;
                            state_q  <= RUN;
                        end else begin
                            ld_cnt_q <= ld_cnt_q + LW'(1);
                        end
                    end
                end
                RUN: begin
                    if (adv) begin
                        idx_q <= idx_q + IW'(1);
                        if (idx_q == '1) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_valid_q && out_last_q && accept) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Stage 1 latches operands; stage 2 registers the product.
            if (adv) begin
                rd_v_q       <= in_run;
                rd_last_q    <= in_run && (idx_q == '1);
                op_a_q       <= in_run ? a_rd : '0;
                op_b_q       <= in_run ? b_rd : '0;
                out_valid_q  <= rd_v_q;
                out_last_q   <= rd_last_q;
                out_matrix_q <= rd_v_q ? prod : '0;
            end
        end
    end

    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_matrix = out_matrix_q;

endmodule

// File: tb/tb_outer_prod_seq.sv
// Directed scoreboard bench for outer_prod_seq.
// Stall scenario is exercised only when OUTER_BACKPRESSURE_EN is defined.
module tb_outer_prod_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       out_valid;
    logic       out_last;
    logic [7:0] out_matrix;
    logic       rdy;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int ecyc = 0;
    int out_count = 0;
    int last_count = 0;
    logic [7:0] got [256];
    logic [8:0] q [$];
    logic [3:0] fa [16];
    logic [3:0] fb [16];
    logic [7:0] pexp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    outer_prod_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_matrix_A (in_a),
        .in_matrix_B (in_b),
`ifdef OUTER_BACKPRESSURE_EN
        .out_ready   (out_ready),
`endif
        .busy        (busy),
        .out_valid   (out_valid),
        .out_matrix  (out_matrix),
        .out_last    (out_last)
    );

`ifdef OUTER_BACKPRESSURE_EN
    assign rdy = out_ready;
`else
    assign rdy = 1'b1;
`endif

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_valid", out_valid, 0);
            end else begin
                chk("out_matrix", out_matrix, q[0][7:0]);
                chk("out_last", out_last, q[0][8]);
                if (rdy) begin
                    void'(q.pop_front());
                    if (out_count < 256) got[out_count] = out_matrix;
                    out_count++;
                    if (out_last) last_count++;
                end
            end
        end else begin
            chk("idle_matrix", out_matrix, 0);
            chk("idle_last", out_last, 0);
        end
    end

    task automatic load(input int gap_after, input int gap_len);
        chk("busy_pre_load", busy, 0);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_a = fa[k];
            in_b = fb[k];
            if (k == 1) chk("busy_rise", busy, 1);
            if (k == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic run_frame(input bit pulse, input bit stall,
                             input int abort_at);
        bit done = 0;
        bit aborted = 0;
        int st = 0;
        bit stalled = 0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                pexp = fa[i] * fb[j];
                q.push_back({(i == 15 && j == 15), pexp});
            end
        end
        out_count = 0;
        last_count = 0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ecyc = cyc;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!busy) begin
                done = 1;
                break;
            end
            if (c == 0) chk("latency_e1", out_valid, 0);
            if (c == 1) chk("latency_e2", out_valid, 1);
            if (abort_at >= 0 && out_count == abort_at) begin
                rst_n = 1'b0;
                in_valid = 1'b0;
                q.delete();
                aborted = 1;
                break;
            end
            in_valid = pulse && c >= 30 && c < 34;
            in_a = '0;
            in_b = '0;
            if (stall && !stalled && out_count == 100) begin
                out_ready = 1'b0;
                st = 5;
                stalled = 1;
            end else if (st > 0) begin
                st--;
                if (st == 0) out_ready = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!aborted) begin
            chk("frame_finished", done, 1);
            chk("busy_fall_cycle", cyc - ecyc, stall ? 263 : 258);
            chk("out_count", out_count, 256);
            chk("last_count", last_count, 1);
            chk("queue_empty", q.size(), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            in_a = 4'($urandom);
            in_b = 4'($urandom);
            @(negedge clk);
            chk("rst_busy", busy, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_matrix", out_matrix, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", out_valid, 0);
        @(posedge clk); #1;

        for (int k = 0; k < 16; k++) begin
            fa[k] = 4'(k);
            fb[k] = 4'(15 - k);
        end
        load(-1, 0);
        run_frame(0, 0, -1);
        chk("c0", got[0], 0);
        chk("c17", got[17], 14);
        chk("c255", got[255], 0);

        for (int k = 0; k < 16; k++) begin
            fa[k] = 4'd15;
            fb[k] = 4'd15;
        end
        load(7, 3);
        run_frame(0, 0, -1);
        chk("c0_max", got[0], 225);
        chk("c255_max", got[255], 225);

        for (int k = 0; k < 16; k++) begin
            fa[k] = 4'($urandom);
            fb[k] = 4'($urandom);
        end
        load(-1, 0);
        run_frame(1, 0, -1);

`ifdef OUTER_BACKPRESSURE_EN
        for (int k = 0; k < 16; k++) begin
            fa[k] = 4'($urandom);
            fb[k] = 4'($urandom);
        end
        load(-1, 0);
        run_frame(0, 1, -1);
        pexp = fa[6] * fb[4];
        chk("c100_stall", got[100], pexp);
`endif

        for (int k = 0; k < 16; k++) begin
            fa[k] = 4'($urandom);
            fb[k] = 4'($urandom);
        end
        load(-1, 0);
        run_frame(0, 0, 50);
        repeat (2) begin
            @(negedge clk);
            chk("abort_busy", busy, 0);
            chk("abort_valid", out_valid, 0);
            chk("abort_matrix", out_matrix, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) begin
            fa[k] = 4'(15 - k);
            fb[k] = 4'($urandom);
        end
        load(-1, 0);
        run_frame(0, 0, -1);
        pexp = fa[0] * fb[0];
        chk("restart_c0", got[0], pexp);
        pexp = fa[3] * fb[2];
        chk("restart_c50", got[50], pexp);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
